// File: rtl/spart.sv
// spart: bus-attached UART with programmable 16-bit baud divisor.
// Ports: clk/rst(async low), iocs/iorw/ioaddr/databus bus, rda/tbr status, txd/rxd serial.
`timescale 1ns/1ps
module spart #(
  parameter logic [15:0] DB_RESET = 16'd2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } st_e;

  logic        wr_en;
  logic        rd_en;
  logic [7:0]  rd_data;

  logic [15:0] db_q, db_d;
  logic [15:0] db_eff;
  logic [15:0] db_half;

  st_e         tx_st_q, tx_st_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [15:0] tx_tmr_q, tx_tmr_d;
  logic        txd_q, txd_d;
  logic        tx_tick;

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  st_e         rx_st_q, rx_st_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [15:0] rx_tmr_q, rx_tmr_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        rda_q, rda_d;
  logic        rx_tick;
  logic        rx_fall;
  logic        rx_load;

  assign wr_en = iocs & ~iorw;
  assign rd_en = iocs & iorw;

  assign tbr = (tx_st_q == S_IDLE);
  assign rda = rda_q;
  assign txd = txd_q;

  always_comb begin
    rd_data = 8'h00;
    unique case (ioaddr)
      2'b00:   rd_data = rx_buf_q;
      2'b01:   rd_data = {6'b0, tbr, rda_q};
      default: rd_data = 8'h00;
    endcase
  end

  assign databus = rd_en ? rd_data : 8'bz;

  // Divisors below 2 would leave no room for a half-bit wait.
  assign db_eff  = (db_q < 16'd2) ? 16'd2 : db_q;
  assign db_half = db_eff >> 1;

  always_comb begin
    db_d = db_q;
    if (wr_en && ioaddr == 2'b10) db_d[7:0]  = databus;
    if (wr_en && ioaddr == 2'b11) db_d[15:8] = databus;
  end

  assign tx_tick = (tx_tmr_q == 16'd0);

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_sh_d  = tx_sh_q;
    tx_idx_d = tx_idx_q;
    tx_tmr_d = tx_tmr_q;
    txd_d    = txd_q;
    unique case (tx_st_q)
      S_IDLE: begin
        if (wr_en && ioaddr == 2'b00) begin
          tx_st_d  = S_START;
          tx_sh_d  = databus;
          tx_tmr_d = db_eff - 16'd1;
          txd_d    = 1'b0;
        end
      end
      S_START: begin
        if (tx_tick) begin
          tx_st_d  = S_DATA;
          tx_idx_d = 3'd0;
          txd_d    = tx_sh_q[0];
          tx_sh_d  = tx_sh_q >> 1;
          tx_tmr_d = db_eff - 16'd1;
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_tick) begin
          tx_tmr_d = db_eff - 16'd1;
          if (tx_idx_q == 3'd7) begin
            tx_st_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            txd_d    = tx_sh_q[0];
            tx_sh_d  = tx_sh_q >> 1;
          end
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_tick) begin
          tx_st_d = S_IDLE;
          txd_d   = 1'b1;
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
    endcase
  end

  assign rx_tick = (rx_tmr_q == 16'd0);
  assign rx_fall = rx_prev_q & ~rx_s2_q;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_sh_d  = rx_sh_q;
    rx_idx_d = rx_idx_q;
    rx_tmr_d = rx_tmr_q;
    rx_load  = 1'b0;
    unique case (rx_st_q)
      S_IDLE: begin
        if (rx_fall) begin
          rx_st_d  = S_START;
          rx_tmr_d = db_half - 16'd1;
        end
      end
      S_START: begin
        if (rx_tick) begin
          // Line back high at mid-start: treat as a glitch.
          if (rx_s2_q) begin
            rx_st_d = S_IDLE;
          end else begin
            rx_st_d  = S_DATA;
            rx_idx_d = 3'd0;
            rx_tmr_d = db_eff - 16'd1;
          end
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_tmr_d = db_eff - 16'd1;
          if (rx_idx_q == 3'd7) rx_st_d = S_STOP;
          else rx_idx_d = rx_idx_q + 3'd1;
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_tick) begin
          rx_st_d = S_IDLE;
          rx_load = rx_s2_q;
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
    endcase
  end

  // Load is applied after the read-clear so a same-cycle new byte wins.
  always_comb begin
    rda_d    = rda_q;
    rx_buf_d = rx_buf_q;
    if (rd_en && ioaddr == 2'b00) rda_d = 1'b0;
    if (rx_load) begin
      rda_d    = 1'b1;
      rx_buf_d = rx_sh_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q      <= DB_RESET;
      tx_st_q   <= S_IDLE;
      tx_sh_q   <= 8'h00;
      tx_idx_q  <= 3'd0;
      tx_tmr_q  <= 16'd0;
      txd_q     <= 1'b1;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_sh_q   <= 8'h00;
      rx_idx_q  <= 3'd0;
      rx_tmr_q  <= 16'd0;
      rx_buf_q  <= 8'h00;
      rda_q     <= 1'b0;
    end else begin
      db_q      <= db_d;
      tx_st_q   <= tx_st_d;
      tx_sh_q   <= tx_sh_d;
      tx_idx_q  <= tx_idx_d;
      tx_tmr_q  <= tx_tmr_d;
      txd_q     <= txd_d;
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_sh_q   <= rx_sh_d;
      rx_idx_q  <= rx_idx_d;
      rx_tmr_q  <= rx_tmr_d;
      rx_buf_q  <= rx_buf_d;
      rda_q     <= rda_d;
    end
  end

endmodule
